codec_adc_deserializer: RTL and testbench

- Serial-to-parallel receiver for the audio codec ADC path, directly upstream of the microphone recorder.
- Oversamples the codec BCLK/ADCLRCK/ADCDAT lines on the 50 MHz system clock and extracts one channel's 16-bit PCM word per frame.
- Presents the word as a held parallel sample plus a one-cycle valid strobe; this bus drives the recorder's mic_in.
- Flags framing errors so the recording FSM can discard corrupt takes.

---
 rtl/codec_adc_deserializer.sv | 81 ++++++++
 tb/tb_codec_adc_deserializer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/codec_adc_deserializer.sv
// codec_adc_deserializer: oversampled I2S/left-justified ADC receiver, one channel to a held parallel word
// Ports:
//   clk, reset_n       50 MHz system clock, asynchronous active-low reset
//   aud_bclk           codec bit clock (async, <= clk/8)
//   aud_adclrck        codec ADC frame/channel clock (async)
//   aud_adcdat         codec ADC serial data, MSB first
//   clear_err          synchronous clear of frame_err (a simultaneous set wins)
//   sample_out         last complete captured word, held between updates
//   sample_valid       one-clk strobe when sample_out updates
//   frame_err          sticky framing-error flag
module codec_adc_deserializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter bit I2S_MODE = 1'b1,
  parameter bit CHANNEL_SEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    aud_bclk,
  input  logic                    aud_adclrck,
  input  logic                    aud_adcdat,
  input  logic                    clear_err,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    frame_err
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;
  state_t state, start_state;
  logic bclk_s1, bclk_s2, bclk_d, lr_s1, lr_s2, dat_s1, dat_s2, lr_cap, primed;
  logic [SAMPLE_WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
  logic bclk_rise, lr_edge, hit, last_bit, start_take, restart, take, err, done;
  assign bclk_rise = bclk_s2 && !bclk_d;
  // primed keeps the very first capture after reset from posing as an LRCK edge
  assign lr_edge = bclk_rise && primed && (lr_s2 != lr_cap);
  assign hit = (I2S_MODE ? lr_s2 : !lr_s2) == CHANNEL_SEL;
  // in I2S the slot that carries the LRCK edge still holds the previous word's LSB
  assign last_bit = I2S_MODE && cnt == CW'(SAMPLE_WIDTH - 1);
  assign start_take = hit && !I2S_MODE;
  assign start_state = !hit ? WAIT : (I2S_MODE ? SKIP : SHIFT);
  assign restart = lr_edge && !(state == SHIFT && last_bit);
  assign err = lr_edge && (state == SKIP || (state == SHIFT && !last_bit));
  assign take = bclk_rise && (restart ? start_take : (state == SKIP || state == SHIFT));
  assign done = state == SHIFT && cnt == CW'(SAMPLE_WIDTH);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {bclk_s1, bclk_s2, bclk_d, lr_s1, lr_s2, dat_s1, dat_s2} <= '0;
      lr_cap       <= 1'b0;
      primed       <= 1'b0;
      sreg         <= '0;
      cnt          <= '0;
      state        <= IDLE;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      {bclk_s1, bclk_s2, bclk_d} <= {aud_bclk, bclk_s1, bclk_s2};
      {lr_s1, lr_s2}             <= {aud_adclrck, lr_s1};
      {dat_s1, dat_s2}           <= {aud_adcdat, dat_s1};
      sample_valid <= done;
      frame_err    <= err || (frame_err && !clear_err);
      if (done) begin
        sample_out <= sreg;
        cnt        <= '0;
        state      <= WAIT;
      end
      if (bclk_rise) begin
        lr_cap <= lr_s2;
        primed <= 1'b1;
      end
      if (take) sreg <= {sreg[SAMPLE_WIDTH-2:0], dat_s2};
      if (restart) begin
        state <= start_state;
        cnt   <= start_take ? CW'(1) : '0;
      end else if (take) begin
        state <= SHIFT;
        cnt   <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_codec_adc_deserializer.sv
// tb_codec_adc_deserializer: directed bench for I2S (left) and left-justified (right) capture
module tb_codec_adc_deserializer;
  logic clk = 0, reset_n = 0, aud_bclk = 1, aud_adclrck = 0, aud_adcdat = 0, clear_err = 0;
  logic [15:0] so_i, so_l;
  logic sv_i, sv_l, fe_i, fe_l;
  int errors = 0, checks = 0, cyc = 0, nv_i = 0, nv_l = 0, vcyc_l = 0, last_rise = 0, base = 0;
  logic prev_bit = 0;
  always #10 clk = ~clk;
  codec_adc_deserializer u_i2s (
    .clk(clk), .reset_n(reset_n), .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck),
    .aud_adcdat(aud_adcdat), .clear_err(clear_err),
    .sample_out(so_i), .sample_valid(sv_i), .frame_err(fe_i)
  );
  codec_adc_deserializer #(.I2S_MODE(1'b0), .CHANNEL_SEL(1'b1)) u_lj (
    .clk(clk), .reset_n(reset_n), .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck),
    .aud_adcdat(aud_adcdat), .clear_err(clear_err),
    .sample_out(so_l), .sample_valid(sv_l), .frame_err(fe_l)
  );
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (sv_i) nv_i++;
    if (sv_l) begin
      nv_l++;
      vcyc_l = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic slot(input logic lr, input logic d, input logic clr);
    aud_bclk = 0; aud_adclrck = lr; aud_adcdat = d;
    repeat (8) @(negedge clk);
    aud_bclk = 1; last_rise = cyc; clear_err = clr;
    repeat (3) @(negedge clk);
    clear_err = 0;
    repeat (5) @(negedge clk);
  endtask
  // I2S data is the left-justified stream delayed by one slot against LRCK
  task automatic half(input logic lr, input logic [15:0] w, input int n, input logic i2s,
                      input logic pad, input logic clr0);
    for (int s = 0; s < n; s++) begin
      logic b;
      b = (s < 16) ? w[15-s] : pad;
      slot(lr, i2s ? prev_bit : b, clr0 && s == 0);
      prev_bit = b;
    end
  endtask
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int n,
                       input logic i2s, input logic pad);
    half(!i2s, l, n, i2s, pad, 1'b0);
    half(i2s, r, n, i2s, pad, 1'b0);
  endtask
  task automatic do_reset;
    reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_i2s", so_i, 0);
    chk("rst_valid_i2s", sv_i, 0);
    chk("rst_err_i2s", fe_i, 0);
    chk("rst_out_lj", so_l, 0);
    reset_n = 1;
    repeat (4) @(negedge clk);
    base = nv_i;
    frame(16'hA5C3, 16'h1234, 16, 1, 0);
    chk("i2s_first_frame_dropped", nv_i - base, 0);
    for (int f = 0; f < 2; f++) begin
      base = nv_i;
      frame(16'hA5C3, 16'h1234, 16, 1, 0);
      chk("i2s_one_valid", nv_i - base, 1);
      chk("i2s_word", so_i, 16'hA5C3);
      chk("i2s_no_err", fe_i, 0);
    end
    base = nv_i;
    frame(16'h8001, 16'h0000, 32, 1, 1);
    chk("slot32_one_valid", nv_i - base, 1);
    chk("slot32_word", so_i, 16'h8001);
    chk("slot32_no_err", fe_i, 0);
    base = nv_i;
    half(0, 16'hDEAD, 10, 1, 0, 0);
    half(1, 16'h1234, 16, 1, 0, 0);
    chk("short_err", fe_i, 1);
    chk("short_no_valid", nv_i - base, 0);
    chk("short_hold", so_i, 16'h8001);
    base = nv_i;
    frame(16'h7FFF, 16'h1234, 16, 1, 0);
    chk("recover_valid", nv_i - base, 1);
    chk("recover_word", so_i, 16'h7FFF);
    chk("err_sticky", fe_i, 1);
    @(negedge clk) clear_err = 1;
    @(negedge clk) clear_err = 0;
    @(negedge clk);
    chk("clear_err", fe_i, 0);
    base = nv_i;
    half(0, 16'hDEAD, 10, 1, 0, 0);
    half(1, 16'h1234, 16, 1, 0, 1);
    chk("set_beats_clear", fe_i, 1);
    chk("set_clear_no_valid", nv_i - base, 0);
    chk("set_clear_hold", so_i, 16'h7FFF);
    do_reset();
    frame(16'hA5C3, 16'h1234, 16, 0, 0);
    for (int f = 0; f < 2; f++) begin
      base = nv_l;
      frame(16'hA5C3, 16'h1234, 16, 0, 0);
      chk("lj_one_valid", nv_l - base, 1);
      chk("lj_word", so_l, 16'h1234);
      chk("lj_no_err", fe_l, 0);
    end
    chk("lj_latency", vcyc_l - last_rise, 4);
    do_reset();
    frame(16'hA5C3, 16'h1234, 16, 1, 0);
    frame(16'hA5C3, 16'h1234, 16, 1, 0);
    chk("pre_reset_word", so_i, 16'hA5C3);
    half(0, 16'h1357, 8, 1, 0, 0);
    aud_bclk = 0;
    repeat (4) @(negedge clk);
    reset_n = 0;
    #1;
    chk("async_rst_out", so_i, 0);
    chk("async_rst_valid", sv_i, 0);
    chk("async_rst_err", fe_i, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
    base = nv_i;
    half(0, 16'h1357, 8, 1, 0, 0);
    half(1, 16'h1234, 16, 1, 0, 0);
    chk("post_rst_partial_dropped", nv_i - base, 0);
    chk("post_rst_out_zero", so_i, 0);
    base = nv_i;
    frame(16'h2468, 16'h1234, 16, 1, 0);
    chk("post_rst_valid", nv_i - base, 1);
    chk("post_rst_word", so_i, 16'h2468);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
